// File: rtl/scan_pat_seq_if.sv
// scan_pat_seq_if: scan pattern stream handshake
// master drives vector words, slave returns ready
interface scan_pat_seq_if #(
   parameter int NCHAIN = 4
);

   logic              pv_valid;
   logic              pv_ready;
   logic [NCHAIN-1:0] pv_si;
   logic [NCHAIN-1:0] pv_exp;
   logic [NCHAIN-1:0] pv_msk;

   modport master (
      output pv_valid,
      output pv_si,
      output pv_exp,
      output pv_msk,
      input  pv_ready
   );

   modport slave (
      input  pv_valid,
      input  pv_si,
      input  pv_exp,
      input  pv_msk,
      output pv_ready
   );

endinterface

// File: rtl/scan_pat_seq.sv
// scan_pat_seq: multi-chain scan pattern sequencer
// overlapped load/unload, capture pulses, miscompare scoring
module scan_pat_seq #(
   parameter int NCHAIN   = 4,
   parameter int LEN_W    = 8,
   parameter int PAT_W    = 10,
   parameter int CAPT_CYC = 1,
   parameter int ERR_W    = 16
) (
   input  logic              clk,
   input  logic              rstz,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [PAT_W-1:0]  cfg_npat,
   input  logic              start,
   input  logic              abort,
   scan_pat_seq_if.slave     pv,
   output logic              scan_en,
   output logic              shift_en,
   output logic              cap_en,
   output logic [NCHAIN-1:0] scan_si,
   input  logic [NCHAIN-1:0] scan_so,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [PAT_W-1:0]  pat_num,
   output logic [31:0]       vec_num,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [PAT_W-1:0]  fail_pat,
   output logic              fail_vld
);

   localparam int PW = $clog2(NCHAIN + 1);
   localparam int SW = ERR_W + PW + 1;
   localparam int CW = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CAPT,
      S_UNLOAD,
      S_DONE
   } state_t;

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  sh_cnt;
   logic [PAT_W-1:0]  npat_q;
   logic [CW-1:0]     cc;

   logic              hs;
   logic              go;
   logic              go_ok;
   logic              last_sh;
   logic              capt_on;
   logic              capt_last;
   logic [PAT_W-1:0]  pat_inc;

   logic [NCHAIN-1:0] mis;
   logic [PW-1:0]     pop;
   logic [SW-1:0]     sum;
   logic [ERR_W-1:0]  err_nx;

   // abort blocks the word in flight, so it gates ready itself
   assign pv.pv_ready = scan_en & ~abort;
   assign hs          = pv.pv_valid & pv.pv_ready;
   assign shift_en    = hs;
   assign scan_si     = hs ? pv.pv_si : '0;

   assign go        = (state == S_IDLE) & start & ~abort;
   assign go_ok     = go & (cfg_len != '0);
   assign last_sh   = sh_cnt == (len_q - LEN_W'(1));
   assign capt_on   = (state == S_CAPT) & ~abort;
   assign capt_last = capt_on & (cc == CW'(CAPT_CYC - 1));
   assign cap_en    = capt_last;
   assign pat_inc   = pat_num + PAT_W'(1);

   // unmasked miscompare bits and saturating error sum
   always_comb begin
      mis = (scan_so ^ pv.pv_exp) & ~pv.pv_msk;
      pop = '0;
      for (int i = 0; i < NCHAIN; i++) begin
         pop = pop + PW'(mis[i]);
      end
      sum = SW'(err_cnt) + SW'(pop);
      if (sum > SW'({ERR_W{1'b1}})) begin
         err_nx = '1;
      end else begin
         err_nx = sum[ERR_W-1:0];
      end
   end

   // sequence FSM with registered scan_en/busy/done
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state   <= S_IDLE;
         scan_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         len_q   <= '0;
         npat_q  <= '0;
         sh_cnt  <= '0;
         cc      <= '0;
      end else if (abort) begin
         state   <= S_IDLE;
         scan_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sh_cnt  <= '0;
         cc      <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go_ok) begin
                  len_q  <= cfg_len;
                  npat_q <= cfg_npat;
                  sh_cnt <= '0;
                  cc     <= '0;
                  if (cfg_npat == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= S_LOAD;
                     scan_en <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
            end
            S_LOAD, S_UNLOAD: begin
               if (hs) begin
                  if (last_sh) begin
                     sh_cnt  <= '0;
                     scan_en <= 1'b0;
                     if (state == S_LOAD) begin
                        state <= S_CAPT;
                     end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     sh_cnt <= sh_cnt + LEN_W'(1);
                  end
               end
            end
            S_CAPT: begin
               if (cc == CW'(CAPT_CYC - 1)) begin
                  cc      <= '0;
                  scan_en <= 1'b1;
                  if (pat_inc == npat_q) begin
                     state <= S_UNLOAD;
                  end else begin
                     state <= S_LOAD;
                  end
               end else begin
                  cc <= cc + CW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // pattern/vector numbering, error scoring, config error flag
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         pat_num  <= '0;
         vec_num  <= '0;
         err_cnt  <= '0;
         fail_pat <= '0;
         fail_vld <= 1'b0;
         cfg_err  <= 1'b0;
      end else if (go_ok) begin
         pat_num  <= '0;
         vec_num  <= '0;
         err_cnt  <= '0;
         fail_pat <= '0;
         fail_vld <= 1'b0;
         cfg_err  <= 1'b0;
      end else if (go) begin
         cfg_err <= 1'b1;
      end else begin
         if (hs) begin
            vec_num <= vec_num + 32'd1;
            err_cnt <= err_nx;
            if ((mis != '0) && !fail_vld) begin
               fail_vld <= 1'b1;
               fail_pat <= pat_num - PAT_W'(1);
            end
         end else if (capt_on) begin
            vec_num <= vec_num + 32'd1;
         end
         if (capt_last) begin
            pat_num <= pat_inc;
         end
      end
   end

endmodule
